pattern_detect_prog: RTL
========================

// Module: pattern_detect_prog
// PURPOSE
//  Runtime-programmable serial bit-pattern detector with per-run match counting.
//  Successor of the fixed "010" FSM detector: pattern and length (1..MAX_LEN) are loaded by a config write.
//  Optional overlap mode and a data_valid qualifier are supported.
//  Sits behind a serial receiver, ahead of framing/control logic that consumes match pulses and counts.
// PARAMETERS
//  MAX_LEN  8  longest supported pattern, in bits (>=2)
//  CNT_W    8  width of the saturating match counter
//  LEN_W    $clog2(MAX_LEN+1)  width of cfg_len (derived localparam, not overridable)
// PORTS
//  clk          in   1        clock, all logic on posedge
//  rst          in   1        synchronous reset, active-high
//  cfg_we       in   1        load cfg_pattern/cfg_len this cycle
//  cfg_pattern  in   MAX_LEN  pattern; bit [len-1] = first bit received, bit [0] = last
//  cfg_len      in   LEN_W    pattern length; 0 = disabled, >MAX_LEN clamped to MAX_LEN
//  overlap      in   1        1: overlapping matches allowed; 0: history restarts after a match
//  data_valid   in   1        data_in accepted this cycle when high
//  data_in      in   1        serial data bit
//  clr_cnt      in   1        clear match_cnt
//  match        out  1        one-cycle pulse, pattern just completed
//  match_cnt    out  CNT_W    matches since last cfg_we/clr_cnt/reset, saturating
//  armed        out  1        high when a nonzero length is configured (state RUN)
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE; pattern, len, hist, fill, match, match_cnt all 0; armed=0.
//  States:
//   - IDLE: no matches. cfg_we with clamped len!=0 -> RUN; otherwise stay IDLE.
//   - RUN: detecting. cfg_we with len==0 -> IDLE.
//   - Any cfg_we (either state): loads pattern/len; clears hist, fill, match_cnt.
//  armed = (state==RUN), registered.
//  Accepted bit (RUN, data_valid=1, cfg_we=0):
//   - hist_n = {hist[MAX_LEN-2:0], data_in}; fill_n = min(fill+1, MAX_LEN).
//   - hit = (fill_n >= len) && (hist_n[len-1:0] == pattern[len-1:0]); bits above len ignored.
//   - hist <= hist_n.
//   - fill <= (hit && !overlap) ? 0 : fill_n.
//  Non-accepted cycle (data_valid=0, or IDLE): hist, fill unchanged; match=0.
//  match <= hit (registered). Latency: pulse in the cycle after the final pattern bit is accepted.
//  match_cnt, evaluated per cycle:
//   - clr_cnt && hit -> 1.
//   - clr_cnt only -> 0.
//   - hit -> +1, holding at 2^CNT_W-1 (saturates, no wrap).
//  Priority: rst > cfg_we > data. The data bit in a cfg_we cycle is dropped; no match that cycle.
//  overlap is sampled every accepted cycle and may change mid-stream. Only fill-clearing on a hit depends on it.
//  len==1: every accepted bit equal to pattern[0] matches, in both overlap modes.
//  Reset mid-stream: partial history discarded; detector returns to IDLE and must be reconfigured.
// TESTING
//  1. cfg len=3 pat=3'b010 overlap=1; bits 0,1,0,1,0,1,0 (valid every cycle) -> match after bits 3,5,7; match_cnt=3.
//  2. Same stimulus, overlap=0 -> match after bits 3 and 7 only; match_cnt=2.
//  3. len=3 pat=010 with data_valid=0 gaps between every bit -> same matches as test 1; match=0 during gaps; cfg len=0 -> armed=0, no matches.
//  4. cfg mid-stream after bits 0,1 then bits 0 -> no match (history cleared); 1,0 -> match.
//  5. CNT_W=2, pat=1 len=1, 5 ones -> match_cnt 1,2,3,3,3.
//  6. clr_cnt with same-cycle hit -> match_cnt=1.
//  7. rst asserted after 2 of 3 pattern bits -> outputs 0, armed=0; further bits give no match until cfg_we.

Source files
------------

// File: rtl/pattern_detect_prog_if.sv
// Purpose : Bundles the configuration, serial data and result signals of the
//           programmable pattern detector into one interface.
// Ports   : master - drives cfg_we/cfg_pattern/cfg_len/overlap/data_valid/
//                    data_in/clr_cnt, observes match/match_cnt/armed
//           slave  - the detector side (mirror of master)
interface pattern_detect_prog_if #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8
);
   localparam int LEN_W = $clog2(MAX_LEN + 1);

   logic               cfg_we;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               overlap;
   logic               data_valid;
   logic               data_in;
   logic               clr_cnt;
   logic               match;
   logic [CNT_W-1:0]   match_cnt;
   logic               armed;

   modport master (
      output cfg_we, cfg_pattern, cfg_len, overlap, data_valid, data_in, clr_cnt,
      input  match, match_cnt, armed
   );

   modport slave (
      input  cfg_we, cfg_pattern, cfg_len, overlap, data_valid, data_in, clr_cnt,
      output match, match_cnt, armed
   );
endinterface

// File: rtl/pattern_detect_prog.sv
// Purpose : Runtime-programmable serial bit-pattern detector with optional
//           overlapping matches, data_valid qualification and a saturating
//           match counter.
// Ports   : clk - clock, all logic on posedge
//           rst - synchronous reset, active-high
//           bus - pattern_detect_prog_if.slave (config, serial data, results)
module pattern_detect_prog #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8
) (
   input logic                  clk,
   input logic                  rst,
   pattern_detect_prog_if.slave bus
);
   localparam int LEN_W = $clog2(MAX_LEN + 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t             state_r, state_n;
   logic [MAX_LEN-1:0] pattern_r, pattern_n;
   logic [LEN_W-1:0]   len_r, len_n;
   logic [MAX_LEN-1:0] hist_r, hist_n;
   logic [LEN_W-1:0]   fill_r, fill_n;
   logic               match_r, match_n;
   logic [CNT_W-1:0]   cnt_r, cnt_n;
   logic               armed_r, armed_n;

   logic [LEN_W-1:0]   len_clamp_s;
   logic               accept_s;
   logic [MAX_LEN-1:0] shift_s;
   logic [LEN_W-1:0]   fill_inc_s;
   logic [MAX_LEN-1:0] mask_s;
   logic               hit_s;

   // Next-state, datapath and output computation for the detector.
   always_comb begin
      state_n   = state_r;
      pattern_n = pattern_r;
      len_n     = len_r;
      hist_n    = hist_r;
      fill_n    = fill_r;
      match_n   = 1'b0;
      cnt_n     = cnt_r;

      len_clamp_s = (bus.cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.cfg_len;
      accept_s    = (state_r == RUN) && bus.data_valid && !bus.cfg_we;
      shift_s     = {hist_r[MAX_LEN-2:0], bus.data_in};
      // fill counts valid history bits and stops at MAX_LEN
      fill_inc_s  = (fill_r == LEN_W'(MAX_LEN)) ? fill_r : fill_r + LEN_W'(1);

      // Only the low len bits of history/pattern take part in the compare
      for (int i = 0; i < MAX_LEN; i++) begin
         mask_s[i] = (LEN_W'(i) < len_r);
      end
      hit_s = accept_s && (fill_inc_s >= len_r) &&
              (((shift_s ^ pattern_r) & mask_s) == {MAX_LEN{1'b0}});

      case (state_r)
         IDLE: begin
            if (bus.cfg_we && (len_clamp_s != {LEN_W{1'b0}})) state_n = RUN;
            else                                              state_n = IDLE;
         end
         RUN: begin
            if (bus.cfg_we && (len_clamp_s == {LEN_W{1'b0}})) state_n = IDLE;
            else                                              state_n = RUN;
         end
         default: state_n = IDLE;
      endcase

      if (bus.cfg_we) begin
         // A config write wins over data: the bit in this cycle is dropped
         pattern_n = bus.cfg_pattern;
         len_n     = len_clamp_s;
         hist_n    = {MAX_LEN{1'b0}};
         fill_n    = {LEN_W{1'b0}};
         cnt_n     = {CNT_W{1'b0}};
      end else begin
         match_n = hit_s;
         if (accept_s) begin
            hist_n = shift_s;
            // Without overlap the next match must be built from fresh bits
            fill_n = (hit_s && !bus.overlap) ? {LEN_W{1'b0}} : fill_inc_s;
         end else begin
            hist_n = hist_r;
            fill_n = fill_r;
         end
         if (bus.clr_cnt) begin
            cnt_n = hit_s ? CNT_W'(1) : {CNT_W{1'b0}};
         end else if (hit_s && !(&cnt_r)) begin
            cnt_n = cnt_r + CNT_W'(1);
         end else begin
            cnt_n = cnt_r;
         end
      end

      armed_n = (state_n == RUN);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         pattern_r <= {MAX_LEN{1'b0}};
         len_r     <= {LEN_W{1'b0}};
         hist_r    <= {MAX_LEN{1'b0}};
         fill_r    <= {LEN_W{1'b0}};
         match_r   <= 1'b0;
         cnt_r     <= {CNT_W{1'b0}};
         armed_r   <= 1'b0;
      end else begin
         state_r   <= state_n;
         pattern_r <= pattern_n;
         len_r     <= len_n;
         hist_r    <= hist_n;
         fill_r    <= fill_n;
         match_r   <= match_n;
         cnt_r     <= cnt_n;
         armed_r   <= armed_n;
      end
   end

   assign bus.match     = match_r;
   assign bus.match_cnt = cnt_r;
   assign bus.armed     = armed_r;
endmodule
